// File: rtl/mem_arbiter_if.sv
// Bundle of requester, response and memory-side signals shared by mem_arbiter.
// The arbiter sits on the slave side; requesters and the memory use the other modports.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0]        req_lock;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [31:0]       req_wdata0;
  logic [31:0]       req_wdata1;
  logic [1:0]        resp_valid;
  logic [31:0]       resp_rdata0;
  logic [31:0]       resp_rdata1;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr_pt;
  logic [31:0]       mem_wr_data;
  logic [31:0]       mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  mem_rd_data,
    output req_ready, resp_valid, resp_rdata0, resp_rdata1,
    output mem_wr_en, mem_addr_pt, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, resp_valid, resp_rdata0, resp_rdata1
  );

  modport mem_side (
    input  mem_wr_en, mem_addr_pt, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port memory, with a bounded lock
// for back-to-back accesses and a registered one-cycle response per transfer.
module mem_arbiter #(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam int CNT_X = CNT_W + 1;

  if (MAX_HOLD < 1 || (64'd1 << ADDR_W) < DEPTH) begin : g_bad_param
    $error("mem_arbiter: MAX_HOLD must be >= 1 and ADDR_W must cover DEPTH");
  end

  logic             prio;
  logic             last;
  logic [CNT_W-1:0] hold_cnt;

  logic             xfer;
  logic             gnt;
  logic             gnt_lock;
  logic [1:0]       ready;
  logic [CNT_X-1:0] cnt_n;

  logic [1:0]       resp_valid_q;
  logic [31:0]      resp_rdata0_q;
  logic [31:0]      resp_rdata1_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    xfer     = |bus.req_valid;
    gnt      = bus.req_valid[1] & (~bus.req_valid[0] | prio);
    ready    = '0;
    if (xfer) ready[gnt] = 1'b1;
    gnt_lock = bus.req_lock[gnt];
    cnt_n    = (gnt == last) ? CNT_X'(hold_cnt) + CNT_X'(1) : CNT_X'(1);

    // With no grant gnt is 0, so address/wdata fall back to port 0.
    bus.mem_addr_pt = gnt ? bus.req_addr1  : bus.req_addr0;
    bus.mem_wr_data = gnt ? bus.req_wdata1 : bus.req_wdata0;
    bus.mem_wr_en   = xfer & bus.req_we[gnt];
  end

  assign bus.req_ready   = ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata0 = resp_rdata0_q;
  assign bus.resp_rdata1 = resp_rdata1_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio          <= 1'b0;
      last          <= 1'b0;
      hold_cnt      <= '0;
      resp_valid_q  <= 2'b00;
      resp_rdata0_q <= '0;
      resp_rdata1_q <= '0;
    end else begin
      resp_valid_q <= 2'b00;
      if (xfer) begin
        resp_valid_q[gnt] <= 1'b1;
        if (gnt) resp_rdata1_q <= bus.req_we[1] ? 32'd0 : bus.mem_rd_data;
        else     resp_rdata0_q <= bus.req_we[0] ? 32'd0 : bus.mem_rd_data;

        prio <= (gnt_lock && cnt_n < CNT_X'(MAX_HOLD)) ? gnt : ~gnt;
        // Saturating at MAX_HOLD keeps the count in range while a lone
        // locked requester runs on; beyond the bound the outcome is the same.
        if (!gnt_lock)                     hold_cnt <= '0;
        else if (cnt_n > CNT_X'(MAX_HOLD)) hold_cnt <= CNT_W'(MAX_HOLD);
        else                               hold_cnt <= cnt_n[CNT_W-1:0];
        last <= gnt;
      end
    end
  end
endmodule
